// File: rtl/heater_pkg.sv
// Shared definitions for the heater actuator stage: FSM states, fault bit positions and
// the saturation ceiling common with the PID stage.
package heater_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int unsigned FAULT_OT = 0;
  localparam int unsigned FAULT_WD = 1;

  localparam logic [11:0] MAX_RANGE = 12'h3F0;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler producing ticks and a period counter wrapping every PERIOD ticks.
// Counters sit at zero whenever clear is asserted.
module pwm_timebase #(
  parameter int unsigned      WIDTH    = 12,
  parameter logic [WIDTH-1:0] PERIOD   = WIDTH'(1008),
  parameter int unsigned      PRESCALE = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             active,
  input  logic             clear,
  output logic [WIDTH-1:0] pcnt,
  output logic             boundary
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick     = active && (presc == PW'(PRESCALE - 1));
  assign boundary = tick && (pcnt == PERIOD - WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      presc <= '0;
      pcnt  <= '0;
    end else if (tick) begin
      presc <= '0;
      pcnt  <= boundary ? '0 : pcnt + WIDTH'(1);
    end else if (active) begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/heater_pwm.sv
// Heater actuator: captures saturated PID responses and drives a period-aligned PWM output,
// with over-temperature cutoff and a watchdog on missing PID results.
module heater_pwm
  import heater_pkg::*;
#(
  parameter int unsigned      WIDTH        = 12,
  parameter logic [WIDTH-1:0] MAX_DUTY     = WIDTH'(MAX_RANGE),
  parameter int unsigned      PRESCALE     = 16,
  parameter int unsigned      WDOG_PERIODS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enable,
  input  logic [WIDTH-1:0] response,
  input  logic             computed,
  input  logic             over_temp,
  input  logic             fault_clr,
  output logic             heater_on,
  output logic [WIDTH-1:0] duty_active,
  output logic             period_start,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int unsigned WDW = $clog2(WDOG_PERIODS + 1);

  state_t           state;
  logic [WIDTH-1:0] duty_pend;
  logic [WIDTH-1:0] sat_resp;
  logic [WIDTH-1:0] pcnt;
  logic [WDW-1:0]   wdog_cnt;
  logic             pend_valid;
  logic             boundary;
  logic             running;
  logic             wdog_trip;
  logic             fault_entry;
  logic             run_hold;

  // Negative responses mean "cool": the heater simply stays off.
  always_comb begin
    sat_resp = response;
    if (response[WIDTH-1]) begin
      sat_resp = '0;
    end else if (response > MAX_DUTY) begin
      sat_resp = MAX_DUTY;
    end
  end

  assign running     = (state == S_RUN);
  assign wdog_trip   = running && boundary && !computed && (wdog_cnt == WDW'(WDOG_PERIODS - 1));
  assign fault_entry = (state != S_FAULT) && (over_temp || wdog_trip);
  assign run_hold    = running && enable && !fault_entry;

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PERIOD  (MAX_DUTY),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .active  (running),
    .clear   (!run_hold),
    .pcnt    (pcnt),
    .boundary(boundary)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      duty_pend    <= '0;
      pend_valid   <= 1'b0;
      duty_active  <= '0;
      wdog_cnt     <= '0;
      heater_on    <= 1'b0;
      period_start <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= '0;
    end else begin
      heater_on    <= 1'b0;
      period_start <= 1'b0;
      if (computed) begin
        duty_pend  <= sat_resp;
        pend_valid <= 1'b1;
        wdog_cnt   <= '0;
      end
      if (fault_entry) begin
        state                <= S_FAULT;
        fault                <= 1'b1;
        duty_active          <= '0;
        wdog_cnt             <= '0;
        fault_code[FAULT_OT] <= fault_code[FAULT_OT] | over_temp;
        fault_code[FAULT_WD] <= fault_code[FAULT_WD] | wdog_trip;
      end else begin
        unique case (state)
          S_IDLE: begin
            wdog_cnt <= '0;
            if (enable) begin
              state       <= S_RUN;
              duty_active <= computed ? sat_resp : (pend_valid ? duty_pend : '0);
              pend_valid  <= 1'b0;
            end
          end
          S_RUN: begin
            heater_on <= (pcnt < duty_active);
            if (!enable) begin
              state <= S_IDLE;
            end else if (boundary) begin
              period_start <= 1'b1;
              // A strobe landing on the boundary takes effect for the period now starting.
              if (computed) begin
                duty_active <= sat_resp;
                pend_valid  <= 1'b0;
              end else begin
                if (pend_valid) begin
                  duty_active <= duty_pend;
                  pend_valid  <= 1'b0;
                end
                wdog_cnt <= wdog_cnt + WDW'(1);
              end
            end
          end
          S_FAULT: begin
            duty_active <= '0;
            wdog_cnt    <= '0;
            if (over_temp) begin
              fault_code[FAULT_OT] <= 1'b1;
            end
            if (fault_clr && !over_temp) begin
              state      <= S_IDLE;
              fault      <= 1'b0;
              fault_code <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_heater_pwm.sv
// Bench for heater_pwm: saturation table, directed multi-period sequences, then random
// stimulus against a cycle-level behavioural model of the actuator.
module tb_heater_pwm;

  localparam int PERIOD = 1008;
  localparam int PRESC  = 1;
  localparam int WDOG   = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] response = '0;
  logic        computed = 1'b0;
  logic        over_temp = 1'b0;
  logic        fault_clr = 1'b0;
  logic        heater_on;
  logic [11:0] duty_active;
  logic        period_start;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 CLK = ~CLK;

  heater_pwm #(
    .WIDTH       (12),
    .MAX_DUTY    (12'h3F0),
    .PRESCALE    (PRESC),
    .WDOG_PERIODS(WDOG)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .enable      (enable),
    .response    (response),
    .computed    (computed),
    .over_temp   (over_temp),
    .fault_clr   (fault_clr),
    .heater_on   (heater_on),
    .duty_active (duty_active),
    .period_start(period_start),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 fault; pos = clock cycles into the period.
  int m_mode = 0, m_pos = 0, m_duty = 0, m_pend = -1, m_quiet = 0, m_code = 0;
  bit m_heat = 0, m_ps = 0;

  function automatic int sat(input int r);
    if (r >= 2048) return 0;
    if (r > PERIOD) return PERIOD;
    return r;
  endfunction

  function automatic bit model_trip_next();
    return (m_mode == 1) && (m_pos == PERIOD * PRESC - 1) && (m_quiet == WDOG - 1);
  endfunction

  task automatic model_update();
    int s;
    bit at_bnd, trip, enter_fault;
    if (!RST_N) begin
      m_mode = 0; m_pos = 0; m_duty = 0; m_pend = -1; m_quiet = 0; m_code = 0;
      m_heat = 0; m_ps = 0;
      return;
    end
    s           = sat(int'(response));
    at_bnd      = (m_mode == 1) && (m_pos == PERIOD * PRESC - 1);
    trip        = at_bnd && !computed && (m_quiet == WDOG - 1);
    enter_fault = (m_mode != 2) && (over_temp || trip);
    m_heat = 0;
    m_ps   = 0;
    if (computed) begin
      m_pend  = s;
      m_quiet = 0;
    end
    if (enter_fault) begin
      m_mode  = 2; m_duty = 0; m_pos = 0; m_quiet = 0;
      m_code |= (over_temp ? 1 : 0) | (trip ? 2 : 0);
    end else begin
      case (m_mode)
        0: begin
          m_quiet = 0;
          if (enable) begin
            m_mode = 1;
            m_duty = computed ? s : ((m_pend >= 0) ? m_pend : 0);
            m_pend = -1;
            m_pos  = 0;
          end
        end
        1: begin
          m_heat = ((m_pos / PRESC) < m_duty);
          if (!enable) begin
            m_mode = 0;
            m_pos  = 0;
          end else if (at_bnd) begin
            m_ps  = 1;
            m_pos = 0;
            if (computed) begin
              m_duty = s;
              m_pend = -1;
            end else begin
              if (m_pend >= 0) begin
                m_duty = m_pend;
                m_pend = -1;
              end
              m_quiet++;
            end
          end else begin
            m_pos++;
          end
        end
        default: begin
          if (over_temp) m_code |= 1;
          if (fault_clr && !over_temp) begin
            m_mode = 0;
            m_code = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for a period start, then spans one whole period counting heater-high cycles.
  // A strobe of resp is issued in the cycle at period offset strobe_at.
  task automatic measure(input int strobe_at, input logic [11:0] resp,
                         output int highs, output int len);
    int w;
    w     = 0;
    highs = 0;
    len   = 0;
    while (!period_start && w < 3 * PERIOD) begin
      step();
      w++;
    end
    if (!period_start) begin
      check("period_start_wait", 32'(period_start), 32'd1);
      return;
    end
    do begin
      if (heater_on) highs++;
      computed = (len == strobe_at);
      response = resp;
      step();
      computed = 1'b0;
      len++;
    end while (!period_start && len < 3 * PERIOD);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {19'd0, heater_on, duty_active, period_start, fault, fault_code}, 32'd0);
  endtask

  typedef struct {
    logic [11:0] resp;
    logic [11:0] duty;
    logic        heat;
  } sat_vec_t;

  sat_vec_t    tbl[10];
  logic [11:0] edge_vals[6];

  initial begin
    int h, l, n;
    tbl[0] = '{12'h1F8, 12'h1F8, 1'b1};
    tbl[1] = '{12'h7FF, 12'h3F0, 1'b1};
    tbl[2] = '{12'h800, 12'h000, 1'b0};
    tbl[3] = '{12'h3F0, 12'h3F0, 1'b1};
    tbl[4] = '{12'h3F1, 12'h3F0, 1'b1};
    tbl[5] = '{12'h000, 12'h000, 1'b0};
    tbl[6] = '{12'hFFF, 12'h000, 1'b0};
    tbl[7] = '{12'h001, 12'h001, 1'b1};
    tbl[8] = '{12'h3EF, 12'h3EF, 1'b1};
    tbl[9] = '{12'h400, 12'h3F0, 1'b1};
    edge_vals[0] = 12'h000; edge_vals[1] = 12'h3F0; edge_vals[2] = 12'h3F1;
    edge_vals[3] = 12'h800; edge_vals[4] = 12'h7FF; edge_vals[5] = 12'h001;

    // Power-on reset.
    RST_N = 1'b0;
    repeat (3) step();
    check_all_zero("reset_outputs");
    RST_N = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // Saturation table: load each response in IDLE, enter RUN, observe duty and first drive.
    for (int i = 0; i < 10; i++) begin
      enable = 1'b0;
      step();
      step();
      computed = 1'b1;
      response = tbl[i].resp;
      step();
      computed = 1'b0;
      enable   = 1'b1;
      step();
      check($sformatf("sat_duty[%0d]", i), 32'(duty_active), 32'(tbl[i].duty));
      step();
      check($sformatf("sat_heat[%0d]", i), 32'(heater_on), 32'(tbl[i].heat));
    end

    // Half duty: 504 of 1008 high.
    enable = 1'b0;
    step();
    step();
    computed = 1'b1;
    response = 12'h1F8;
    step();
    computed = 1'b0;
    enable   = 1'b1;
    step();
    measure(300, 12'h1F8, h, l);
    check("half_duty_highs", 32'(h), 32'd504);
    check("half_duty_len", 32'(l), 32'd1008);

    // Mid-period strobe defers to next period; boundary strobe applies at once.
    measure(300, 12'h100, h, l);
    check("mid_strobe_cur", 32'(h), 32'd504);
    measure(300, 12'h100, h, l);
    check("mid_strobe_next", 32'(h), 32'd256);
    check("mid_strobe_len", 32'(l), 32'd1008);
    measure(1007, 12'h080, h, l);
    check("bnd_strobe_prev", 32'(h), 32'd256);
    check("bnd_strobe_duty", 32'(duty_active), 32'h080);
    measure(300, 12'h080, h, l);
    check("bnd_strobe_highs", 32'(h), 32'd128);

    // Saturated extremes over whole periods.
    measure(1007, 12'h7FF, h, l);
    measure(300, 12'h7FF, h, l);
    measure(300, 12'h7FF, h, l);
    check("full_duty_highs", 32'(h), 32'd1008);
    check("full_duty_value", 32'(duty_active), 32'h3F0);
    measure(1007, 12'h800, h, l);
    measure(300, 12'h800, h, l);
    measure(300, 12'h800, h, l);
    check("neg_duty_highs", 32'(h), 32'd0);
    check("neg_duty_value", 32'(duty_active), 32'h000);

    // Over-temperature cutoff at pcnt 10 of a 504 period.
    measure(1007, 12'h1F8, h, l);
    repeat (10) step();
    check("ot_pre_heat", 32'(heater_on), 32'd1);
    over_temp = 1'b1;
    step();
    check("ot_heat_off", 32'(heater_on), 32'd0);
    check("ot_fault", {29'd0, fault, fault_code}, 32'b101);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step();
    check("ot_clr_ignored", {29'd0, fault, fault_code}, 32'b101);
    over_temp = 1'b0;
    step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("ot_cleared", {29'd0, fault, fault_code}, 32'b000);

    // Watchdog: two silent boundaries in RUN.
    n = 0;
    while (!fault && n < 4 * PERIOD) begin
      step();
      n++;
    end
    check("wdog_cycles", 32'(n), 32'd2017);
    check("wdog_fault", {29'd0, fault, fault_code}, 32'b110);
    check("wdog_heat", 32'(heater_on), 32'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    n = 0;
    while (!model_trip_next() && n < 4 * PERIOD) begin
      step();
      n++;
    end
    over_temp = 1'b1;
    step();
    check("wdog_ot_code", {29'd0, fault, fault_code}, 32'b111);
    over_temp = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;

    // Reset held mid-RUN.
    computed = 1'b1;
    response = 12'h1F8;
    step();
    computed = 1'b0;
    repeat (100) step();
    check("pre_reset_heat", 32'(heater_on), 32'd1);
    RST_N = 1'b0;
    repeat (3) step();
    check_all_zero("midrun_reset");
    RST_N  = 1'b1;
    enable = 1'b0;
    step();
    check_all_zero("midrun_reset_idle");

    // Random stimulus against the model.
    enable = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      RST_N = ($urandom_range(0, 4999) != 0);
      if ($urandom_range(0, 999) == 0) enable = ~enable;
      computed = ($urandom_range(0, 1199) == 0);
      if ($urandom_range(0, 3) == 0) response = edge_vals[$urandom_range(0, 5)];
      else response = 12'($urandom_range(0, 4095));
      if (!over_temp) over_temp = ($urandom_range(0, 2999) == 0);
      else over_temp = ($urandom_range(0, 29) != 0);
      fault_clr = ($urandom_range(0, 99) == 0);
      step();
      check("random_outputs",
            {14'd0, heater_on, duty_active, period_start, fault, fault_code},
            {14'd0, m_heat, 12'(m_duty), m_ps, (m_mode == 2), 2'(m_code)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
